// File: rtl/icache_controller.sv
// icache_controller: direct-mapped, read-only instruction cache for the fetch stage.
// Hits return the instruction combinationally with stall=0; a miss stalls while a
// whole line is refilled over a valid/ready burst interface from instruction memory.
// Optional statistics counters are built when ICACHE_STATS_EN is defined.
module icache_controller #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF = $clog2(WORDS);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 32 - IDX - OFF;
  localparam logic [31:0]    NOP       = 32'h2100_0000;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  // Storage: data and tags carry no reset, only the valid bits do
  logic [31:0]    data_arr [LINES*WORDS];
  logic [TAG-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid_r;

  state_t             state_r;
  logic [TAG+IDX-1:0] miss_line_r;
  logic [OFF-1:0]     beat_r;
  logic               flush_pend_r;
  logic               mem_req_valid_r;
  logic [31:0]        mem_req_addr_r;

  logic [OFF-1:0] off_s;
  logic [IDX-1:0] idx_s;
  logic [TAG-1:0] tag_s;
  logic [IDX-1:0] fill_idx_s;
  logic [TAG-1:0] fill_tag_s;
  logic           hit_s;
  logic           stall_s;
  logic [31:0]    instr_s;

  assign off_s      = addr[OFF-1:0];
  assign idx_s      = addr[OFF+IDX-1:OFF];
  assign tag_s      = addr[31:OFF+IDX];
  assign fill_idx_s = miss_line_r[IDX-1:0];
  assign fill_tag_s = miss_line_r[TAG+IDX-1:IDX];

  // Tag compare and hit/stall/instruction selection for the current fetch address
  always_comb begin
    hit_s   = 1'b0;
    stall_s = 1'b1;
    instr_s = NOP;
    if (valid_r[idx_s] && (tag_arr[idx_s] == tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    if ((state_r == ST_LOOKUP) && hit_s && !flush && !flush_pend_r) begin
      stall_s = 1'b0;
      instr_s = data_arr[{idx_s, off_s}];
    end else begin
      stall_s = 1'b1;
      instr_s = NOP;
    end
  end

  assign stall         = stall_s;
  assign instr         = instr_s;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = mem_req_addr_r;

  // Control FSM: lookup, refill request handshake, beat collection, flush handling
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r         <= ST_LOOKUP;
      valid_r         <= {LINES{1'b0}};
      miss_line_r     <= {(TAG+IDX){1'b0}};
      beat_r          <= {OFF{1'b0}};
      flush_pend_r    <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_LOOKUP: begin
          if (flush || flush_pend_r) begin
            // A deferred flush also drops the line that was just refilled
            valid_r      <= {LINES{1'b0}};
            flush_pend_r <= 1'b0;
          end else if (!hit_s) begin
            miss_line_r     <= {tag_s, idx_s};
            mem_req_valid_r <= 1'b1;
            mem_req_addr_r  <= {tag_s, idx_s, {OFF{1'b0}}};
            state_r         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            beat_r          <= {OFF{1'b0}};
            state_r         <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (mem_resp_valid) begin
            beat_r <= beat_r + OFF'(1);
            if (beat_r == LAST_BEAT) begin
              valid_r[fill_idx_s] <= 1'b1;
              state_r             <= ST_LOOKUP;
            end
          end
        end
        default: begin
          state_r         <= ST_LOOKUP;
          mem_req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Refill writes into the unreset data/tag arrays; blocked while reset is held
  always_ff @(posedge clock) begin
    if (reset && (state_r == ST_FILL) && mem_resp_valid) begin
      data_arr[{fill_idx_s, beat_r}] <= mem_resp_data;
      if (beat_r == LAST_BEAT) begin
        tag_arr[fill_idx_s] <= fill_tag_s;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Count clean hits and misses that launch a refill request
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if ((state_r == ST_LOOKUP) && !flush && !flush_pend_r) begin
      if (hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end else begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller (default LINES=64, WORDS=4).
// A behavioural backing memory answers refill requests; fetched instructions are
// predicted into a scoreboard queue and compared when the cache stops stalling.
// Counter ports are connected when ICACHE_STATS_EN is defined.
module tb_icache_controller;

  localparam logic [31:0] NOP = 32'h2100_0000;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_controller dut (
    .clock          (clock),
    .reset          (reset),
    .addr           (addr),
    .instr          (instr),
    .stall          (stall),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Backing memory model state
  bit          busy      = 1'b0;
  int          beats     = 0;
  int          wait_cnt  = 0;
  int          req_wait  = 0;
  bit          gap_mode  = 1'b0;
  bit          gap_phase = 1'b0;
  logic [31:0] base      = 32'd0;

  // Outputs sampled 1 time unit after the negative edge
  logic        obs_stall;
  logic [31:0] obs_instr;
  logic        obs_rv;
  logic [31:0] obs_ra;

  logic [31:0] sb_q [$];

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        exp_stall;
    logic [31:0] exp_instr;
    logic        exp_rv;
    logic [31:0] exp_ra;
  } vec_t;

  vec_t tbl [$];

  // Contents of backing memory: words 0..3 are 0xA0..0xA3, each line distinct
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) << 12) | (32'h0000_00A0 + {30'd0, a[1:0]});
  endfunction

  function automatic vec_t row(input logic [31:0] a, input logic f, input logic s,
                               input logic rv, input logic [31:0] ra);
    vec_t r;
    r.addr      = a;
    r.flush     = f;
    r.exp_stall = s;
    r.exp_instr = s ? NOP : mem_word(a);
    r.exp_rv    = rv;
    r.exp_ra    = ra;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive memory inputs, sample outputs, advance the memory model
  task automatic tick();
    mem_req_ready = (mem_req_valid === 1'b1) && (wait_cnt >= req_wait);
    if (busy && !(gap_mode && gap_phase)) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(base + 32'(beats));
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    obs_stall = stall;
    obs_instr = instr;
    obs_rv    = mem_req_valid;
    obs_ra    = mem_req_addr;
    @(posedge clock);
    if (reset === 1'b0) begin
      busy     = 1'b0;
      beats    = 0;
      wait_cnt = 0;
    end else begin
      if (busy && mem_resp_valid) begin
        beats++;
        if (beats == 4) busy = 1'b0;
      end
      if (obs_rv === 1'b1 && mem_req_ready) begin
        busy     = 1'b1;
        base     = obs_ra;
        beats    = 0;
        wait_cnt = 0;
      end else if (obs_rv === 1'b1) begin
        wait_cnt++;
      end
      gap_phase = !gap_phase;
    end
    @(negedge clock);
  endtask

  // Fetch-stage model: hold pc until stall drops, then pop and compare the instruction
  task automatic fetch(input logic [31:0] pc, input int exp_stalls, input int exp_rv,
                       input string name);
    int stalls = 0;
    int rv_cnt = 0;
    int ra_bad = 0;
    bit done   = 1'b0;
    logic [31:0] line_a;
    line_a = {pc[31:2], 2'b00};
    addr   = pc;
    flush  = 1'b0;
    sb_q.push_back(mem_word(pc));
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (obs_rv === 1'b1) begin
        rv_cnt++;
        if (obs_ra !== line_a) ra_bad++;
      end
      if (obs_stall === 1'b0) begin
        done = 1'b1;
        check({name, " instr"}, obs_instr, sb_q.pop_front());
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s timeout: stall still 1 after 200 cycles, expected 0", name);
    end
    if (exp_stalls >= 0) check({name, " stall cycles"}, stalls, exp_stalls);
    check({name, " req_valid cycles"}, rv_cnt, exp_rv);
    check({name, " req_addr mismatches"}, ra_bad, 0);
    if (exp_rv > 0) check({name, " beats before hit"}, beats, 4);
  endtask

  initial begin
    addr           = 32'd0;
    flush          = 1'b0;
    reset          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;

    // Reset state
    repeat (3) tick();
    check("reset req_valid", {31'd0, obs_rv}, 32'd0);
    check("reset stall", {31'd0, obs_stall}, 32'd1);
    check("reset instr", obs_instr, NOP);
    reset = 1'b1;

    // Test 1: cold miss at address 0
    fetch(32'd0, 6, 1, "t1 cold miss");

    // Test 2 plus flush in LOOKUP and address change during refill, cycle by cycle
    tbl.push_back(row(32'd1, 1'b0, 1'b0, 1'b0, 32'd0));
    tbl.push_back(row(32'd2, 1'b0, 1'b0, 1'b0, 32'd0));
    tbl.push_back(row(32'd3, 1'b0, 1'b0, 1'b0, 32'd0));
    tbl.push_back(row(32'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    tbl.push_back(row(32'd2, 1'b1, 1'b1, 1'b0, 32'd0));
    tbl.push_back(row(32'd2, 1'b0, 1'b1, 1'b0, 32'd0));
    tbl.push_back(row(32'd2, 1'b0, 1'b1, 1'b1, 32'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(row(32'd5, 1'b0, 1'b1, 1'b0, 32'd0));
    tbl.push_back(row(32'd5, 1'b0, 1'b1, 1'b1, 32'd4));
    for (int i = 0; i < 4; i++) tbl.push_back(row(32'd5, 1'b0, 1'b1, 1'b0, 32'd0));
    tbl.push_back(row(32'd5, 1'b0, 1'b0, 1'b0, 32'd0));
    tbl.push_back(row(32'd2, 1'b0, 1'b0, 1'b0, 32'd0));
    foreach (tbl[i]) begin
      addr  = tbl[i].addr;
      flush = tbl[i].flush;
      tick();
      check($sformatf("row%0d stall", i), {31'd0, obs_stall}, {31'd0, tbl[i].exp_stall});
      check($sformatf("row%0d instr", i), obs_instr, tbl[i].exp_instr);
      check($sformatf("row%0d req_valid", i), {31'd0, obs_rv}, {31'd0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) check($sformatf("row%0d req_addr", i), obs_ra, tbl[i].exp_ra);
    end
    flush = 1'b0;

    // Test 3: conflicting tag evicts line 0, then address 0 misses again
    fetch(32'h100, 6, 1, "t3 conflict");
    fetch(32'h0, 6, 1, "t3 refetch");

    // Test 4: slow request acceptance and gapped beats
    req_wait  = 5;
    gap_mode  = 1'b1;
    gap_phase = 1'b0;
    fetch(32'h204, -1, 6, "t4 slow refill");
    req_wait  = 0;
    gap_mode  = 1'b0;
    fetch(32'h205, 0, 0, "t4 word1");
    fetch(32'h206, 0, 0, "t4 word2");
    fetch(32'h207, 0, 0, "t4 word3");

    // Test 5: flush pulsed during FILL
    addr = 32'h8;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    check("t5 stall at flush", {31'd0, obs_stall}, 32'd1);
    flush = 1'b0;
    fetch(32'h8, 9, 1, "t5 flush in fill");
    fetch(32'h0, 6, 1, "t5 others cleared");

    // Test 6: reset during FILL beat 2
    addr = 32'hC;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("t6 req_valid after reset", {31'd0, mem_req_valid}, 32'd0);
    check("t6 stall after reset", {31'd0, stall}, 32'd1);
`ifdef ICACHE_STATS_EN
    check("t6 hit_count", hit_count, 32'd0);
    check("t6 miss_count", miss_count, 32'd0);
`endif
    fetch(32'hC, 6, 1, "t6 refetch");
    fetch(32'hD, 0, 0, "t6 word1");

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
